light_chaser_param: RTL and testbench
=====================================

LIGHT_CHASER_PARAM -- requirements
Module: light_chaser_param

Interface
REQ-001 SHALL provide parameter NUM_LEDS, default 8, number of LED outputs (legal 4..32).
REQ-002 SHALL provide parameter DIV_W, default 8, width of step-divider input.
REQ-003 SHALL provide parameter POS_W, default 6, width of pos output (holds 0..NUM_LEDS).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  high = advance prescaler/pattern; low = freeze.
REQ-007 SHALL have port mode  input  2  pattern select: 0 chase, 1 bounce, 2 bar, 3 alternate.
REQ-008 SHALL have port dir  input  1  0 = toward MSB, 1 = toward LSB (chase and bar only).
REQ-009 SHALL have port step_div  input  DIV_W  step period = step_div+1 enabled cycles.
REQ-010 SHALL have port l  output  NUM_LEDS  LED pattern, decoded from registered state only.
REQ-011 SHALL have port pos  output  POS_W  current position/level register.
REQ-012 SHALL have port step  output  1  registered one-cycle pulse, cycle after each pattern step.
REQ-013 SHALL have port wrap  output  1  registered one-cycle pulse, cycle after pattern period completes.

Function
REQ-014 Prescaler cnt SHALL increment on each enabled cycle; when cnt >= step_div it SHALL clear to 0 and issue one pattern step that cycle.
REQ-015 Lowering step_div below the current cnt SHALL cause a step on the next enabled cycle; no lockup.
REQ-016 enable low SHALL hold cnt, pos, internal direction, phase and l unchanged; step and wrap SHALL be 0.
REQ-017 Chase (mode 0): l = one-hot bit pos. dir=0: pos+1, N-1 -> 0 with wrap. dir=1: pos-1, 0 -> N-1 with wrap.
REQ-018 Chase: a dir change SHALL take effect at the next step without restarting.
REQ-019 Bounce (mode 1): l = one-hot bit pos; internal up/down flag; sequence 0,1..N-1,N-2..1,0,1..; reversal at each end with no repeated end position; period 2N-2 steps; wrap on the step that lands pos on 0; dir ignored.
REQ-020 Bar (mode 2): pos is a level 0..N. dir=0 lights the lowest pos bits; dir=1 lights the highest pos bits. Each step increments the level; from N the next step returns to 0 with wrap. Period N+1 steps.
REQ-021 Alternate (mode 3): phase bit; l = ...0101 (bit0 = 1) when phase = 0, bitwise inverse when phase = 1; each step toggles phase; wrap on each 1 -> 0 toggle; pos held 0.
REQ-022 mode SHALL be registered (mode_q). When mode != mode_q, the next edge SHALL set mode_q = mode and clear pos, cnt and phase, set the up flag, and suppress any step that cycle; this applies even with enable low.
REQ-023 step and wrap SHALL never assert in the same cycle as reset or a mode restart.

Reset
REQ-024 While reset = 1, reset SHALL dominate enable and mode change: cnt=0, pos=0, phase=0, up flag set, mode_q=mode, step=0, wrap=0.
REQ-025 After reset, l SHALL be: mode 0/1 -> bit0 only; mode 2 -> all 0; mode 3 -> ...0101.
REQ-026 Reset asserted mid-step or mid-period SHALL discard the pending step; the first step after release SHALL come step_div+1 enabled cycles later.

Verification
REQ-027 N=8, mode 0, dir=0, step_div=2, enable=1 -> l advances every 3 cycles: 0x01, 0x02 ... 0x80, 0x01; wrap pulses once per 24 cycles.
REQ-028 N=8, mode 1, step_div=0 -> pos 0..7..0 in 14 cycles, each end lit exactly one cycle; wrap when pos returns to 0.
REQ-029 N=8, mode 2, dir=1, step_div=0 -> l = 0x00, 0x80, 0xC0 ... 0xFF, 0x00; wrap on the 0xFF -> 0x00 step.
REQ-030 Running mode 0 at pos=5: switch mode to 3 -> next cycle l = 0x55, pos = 0, cnt = 0, no step pulse; toggles to 0xAA after step_div+1 cycles.
REQ-031 enable low for 10 cycles mid-count -> l, pos, cnt frozen, no pulses; resumes with the remaining count intact.
REQ-032 reset pulsed with enable=1 at pos=6 -> l = 0x01 next cycle, step/wrap 0; first step step_div+1 cycles after release.

Source files
------------

// File: rtl/light_chaser_param.sv
// light_chaser_param
//   Parameterised LED chaser with four patterns (chase, bounce, bar,
//   alternate) advanced by a programmable prescaler.
//
// Ports
//   clk       in   sole clock, all state updates on the rising edge
//   reset     in   synchronous, active-high; dominates enable and mode change
//   enable    in   1 = advance prescaler/pattern, 0 = freeze everything
//   mode      in   [1:0] 0 chase, 1 bounce, 2 bar, 3 alternate
//   dir       in   0 = toward MSB, 1 = toward LSB (chase and bar only)
//   step_div  in   [DIV_W-1:0] step period = step_div+1 enabled cycles
//   l         out  [NUM_LEDS-1:0] LED pattern, decoded from registered state
//   pos       out  [POS_W-1:0] current position (chase/bounce) or level (bar)
//   step      out  one-cycle pulse in the cycle after each pattern step
//   wrap      out  one-cycle pulse in the cycle after a pattern period ends
//
// There is no request/acknowledge handshake on this block: every input is
// sampled on each rising edge and every output is a plain registered level
// or one-cycle pulse.

module light_chaser_param #(
  parameter int NUM_LEDS = 8,
  parameter int DIV_W    = 8,
  parameter int POS_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic                dir,
  input  logic [DIV_W-1:0]    step_div,
  output logic [NUM_LEDS-1:0] l,
  output logic [POS_W-1:0]    pos,
  output logic                step,
  output logic                wrap
);

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BAR    = 2'd2,
    MODE_ALT    = 2'd3
  } mode_t;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] POS_TOP  = POS_W'(NUM_LEDS);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  // Registered state
  mode_t              r_mode_q;
  logic [DIV_W-1:0]   r_cnt;
  logic [POS_W-1:0]   r_pos;
  logic               r_up;
  logic               r_phase;
  logic               r_dir;
  logic               r_step;
  logic               r_wrap;

  // Next-state values
  mode_t              w_mode_nxt;
  logic [DIV_W-1:0]   w_cnt_nxt;
  logic [POS_W-1:0]   w_pos_nxt;
  logic               w_up_nxt;
  logic               w_phase_nxt;
  logic               w_dir_nxt;
  logic               w_step_nxt;
  logic               w_wrap_nxt;
  logic               w_restart;

  assign w_restart = (mode != r_mode_q);

  // Next-state logic. A mode change restarts the pattern regardless of
  // enable, and never produces a step in the same cycle.
  always_comb begin
    w_mode_nxt  = r_mode_q;
    w_cnt_nxt   = r_cnt;
    w_pos_nxt   = r_pos;
    w_up_nxt    = r_up;
    w_phase_nxt = r_phase;
    w_dir_nxt   = r_dir;
    w_step_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;

    if (w_restart) begin
      w_mode_nxt  = mode_t'(mode);
      w_cnt_nxt   = '0;
      w_pos_nxt   = '0;
      w_up_nxt    = 1'b1;
      w_phase_nxt = 1'b0;
      w_dir_nxt   = dir;
    end else if (enable) begin
      // dir is captured only on enabled cycles so the bar display cannot
      // change while the chaser is frozen.
      w_dir_nxt = dir;
      // >= (not ==) so lowering step_div below cnt steps at once instead
      // of counting all the way round the counter.
      if (r_cnt >= step_div) begin
        w_cnt_nxt  = '0;
        w_step_nxt = 1'b1;
        case (r_mode_q)
          MODE_CHASE: begin
            // dir is sampled at step time: a change applies from the next step.
            if (!dir) begin
              if (r_pos >= POS_LAST) begin
                w_pos_nxt  = '0;
                w_wrap_nxt = 1'b1;
              end else begin
                w_pos_nxt = r_pos + POS_ONE;
              end
            end else begin
              if (r_pos == '0) begin
                w_pos_nxt  = POS_LAST;
                w_wrap_nxt = 1'b1;
              end else begin
                w_pos_nxt = r_pos - POS_ONE;
              end
            end
          end
          MODE_BOUNCE: begin
            // Reverse at each end without revisiting the end position.
            if (r_up) begin
              if (r_pos >= POS_LAST) begin
                w_pos_nxt = POS_LAST - POS_ONE;
                w_up_nxt  = 1'b0;
              end else begin
                w_pos_nxt = r_pos + POS_ONE;
              end
            end else begin
              if (r_pos <= POS_ONE) begin
                w_pos_nxt  = '0;
                w_up_nxt   = 1'b1;
                w_wrap_nxt = 1'b1;
              end else begin
                w_pos_nxt = r_pos - POS_ONE;
              end
            end
          end
          MODE_BAR: begin
            if (r_pos >= POS_TOP) begin
              w_pos_nxt  = '0;
              w_wrap_nxt = 1'b1;
            end else begin
              w_pos_nxt = r_pos + POS_ONE;
            end
          end
          default: begin
            w_phase_nxt = ~r_phase;
            w_wrap_nxt  = r_phase;
            w_pos_nxt   = '0;
          end
        endcase
      end else begin
        w_cnt_nxt = r_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_q <= mode_t'(mode);
      r_cnt    <= '0;
      r_pos    <= '0;
      r_up     <= 1'b1;
      r_phase  <= 1'b0;
      r_dir    <= dir;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_mode_q <= w_mode_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pos    <= w_pos_nxt;
      r_up     <= w_up_nxt;
      r_phase  <= w_phase_nxt;
      r_dir    <= w_dir_nxt;
      r_step   <= w_step_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  // LED decode, purely from registered state.
  always_comb begin
    l = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (r_mode_q)
        MODE_CHASE, MODE_BOUNCE: l[i] = (r_pos == POS_W'(i));
        MODE_BAR: begin
          if (!r_dir) l[i] = (POS_W'(i) < r_pos);
          else        l[i] = (POS_W'(i) >= (POS_TOP - r_pos));
        end
        default:    l[i] = ((i % 2) == 0) ^ r_phase;
      endcase
    end
  end

  assign pos  = r_pos;
  assign step = r_step;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_light_chaser_param.sv
// tb_light_chaser_param
//   Directed scenarios followed by randomized stimulus for light_chaser_param
//   (NUM_LEDS=8). A behavioural model predicts {l, pos, step, wrap} after
//   every clock edge; predictions go through an expected queue and are
//   compared with immediate assertions.

module tb_light_chaser_param;

  localparam int N     = 8;
  localparam int DIV_W = 8;
  localparam int POS_W = 6;
  localparam int W     = N + POS_W + 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic             enable;
  logic [1:0]       mode;
  logic             dir;
  logic [DIV_W-1:0] step_div;
  logic [N-1:0]     l;
  logic [POS_W-1:0] pos;
  logic             step;
  logic             wrap;

  light_chaser_param #(.NUM_LEDS(N), .DIV_W(DIV_W), .POS_W(POS_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .dir      (dir),
    .step_div (step_div),
    .l        (l),
    .pos      (pos),
    .step     (step),
    .wrap     (wrap)
  );

  // ---------------- reference model ----------------
  // Bounce is modelled as a step index k over its 2N-2 step period, with the
  // position folded from k; bar as a level counted modulo N+1; chase as a
  // position modulo N.
  int m_cnt, m_pos, m_k, m_phase, m_mode_q, m_dir_q, m_step, m_wrap;

  function automatic int model_pos();
    if (m_mode_q == 1) return (m_k < N) ? m_k : (2 * N - 2 - m_k);
    if (m_mode_q == 3) return 0;
    return m_pos;
  endfunction

  function automatic logic [N-1:0] model_leds();
    int p;
    int v;
    p = model_pos();
    case (m_mode_q)
      0, 1: v = 1 << p;
      2:    v = m_dir_q ? (((1 << p) - 1) << (N - p)) : ((1 << p) - 1);
      default: v = m_phase ? 8'hAA : 8'h55;
    endcase
    return N'(v);
  endfunction

  task automatic model_edge();
    m_step = 0;
    m_wrap = 0;
    if (reset || (int'(mode) != m_mode_q)) begin
      m_mode_q = int'(mode);
      m_cnt = 0; m_pos = 0; m_k = 0; m_phase = 0;
      m_dir_q = int'(dir);
    end else if (enable) begin
      m_dir_q = int'(dir);
      if (m_cnt >= int'(step_div)) begin
        m_cnt  = 0;
        m_step = 1;
        case (m_mode_q)
          0: begin
            m_pos  = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
            m_wrap = dir ? int'(m_pos == N - 1) : int'(m_pos == 0);
          end
          1: begin
            m_k    = (m_k + 1) % (2 * N - 2);
            m_wrap = int'(m_k == 0);
          end
          2: begin
            m_pos  = (m_pos + 1) % (N + 1);
            m_wrap = int'(m_pos == 0);
          end
          default: begin
            m_phase = 1 - m_phase;
            m_wrap  = int'(m_phase == 0);
          end
        endcase
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_cycle(input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    exp_v = exp_q.pop_front();
    act_v = {l, pos, step, wrap};
    checks++;
    assert (act_v === exp_v) else begin
      failures++;
      $error("FAIL %s: got l=%h pos=%0d step=%b wrap=%b, want l=%h pos=%0d step=%b wrap=%b",
             tag, act_v[W-1 -: N], act_v[POS_W+1:2], act_v[1], act_v[0],
             exp_v[W-1 -: N], exp_v[POS_W+1:2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic d, input int sd);
    reset    = r;
    enable   = e;
    mode     = m;
    dir      = d;
    step_div = DIV_W'(sd);
  endtask

  // One clock: predict, advance, compare.
  task automatic tick(input string tag);
    model_edge();
    exp_q.push_back({model_leds(), POS_W'(model_pos()), m_step[0], m_wrap[0]});
    @(posedge clk);
    #1;
    check_cycle(tag);
  endtask

  // ---------------- stimulus ----------------
  int n_wrap, n_top, n_zero, n_cyc;
  logic [N-1:0] last_l;

  initial begin
    m_cnt = 0; m_pos = 0; m_k = 0; m_phase = 0;
    m_mode_q = 0; m_dir_q = 0; m_step = 0; m_wrap = 0;

    // Reset state, chase mode
    drive(1'b1, 1'b1, 2'd0, 1'b0, 2);
    tick("reset0");
    tick("reset1");
    check_val("reset_l_chase", int'(l), 'h01);
    check_val("reset_pos", int'(pos), 0);
    check_val("reset_pulses", int'({step, wrap}), 0);

    // Chase up, step_div=2: one wrap per 24 cycles
    drive(1'b0, 1'b1, 2'd0, 1'b0, 2);
    n_wrap = 0;
    for (int i = 0; i < 24; i++) begin
      tick("chase_up");
      n_wrap += int'(wrap);
    end
    check_val("chase_wrap_per_24", n_wrap, 1);
    check_val("chase_back_to_bit0", int'(l), 'h01);

    // Chase down briefly, then run until pos 5
    dir = 1'b1;
    for (int i = 0; i < 9; i++) tick("chase_down");
    dir = 1'b0;
    n_cyc = 0;
    while (m_pos != 5 && n_cyc < 60) begin
      tick("chase_to5");
      n_cyc++;
    end
    check_val("chase_reached_pos5", int'(pos), 5);

    // Mode switch to alternate mid-run
    mode = 2'd3;
    tick("mode_to_alt");
    check_val("alt_restart_l", int'(l), 'h55);
    check_val("alt_restart_pos", int'(pos), 0);
    check_val("alt_restart_nostep", int'(step), 0);
    for (int i = 0; i < 3; i++) tick("alt_run");
    check_val("alt_toggled", int'(l), 'hAA);
    for (int i = 0; i < 6; i++) tick("alt_run2");

    // Bounce, step_div=0
    drive(1'b0, 1'b1, 2'd1, 1'b0, 0);
    tick("bounce_restart");
    n_wrap = 0; n_top = 0; n_zero = 0;
    for (int i = 0; i < 14; i++) begin
      tick("bounce");
      n_wrap += int'(wrap);
      n_top  += int'(pos == 7);
      n_zero += int'(pos == 0);
    end
    check_val("bounce_wrap_per_14", n_wrap, 1);
    check_val("bounce_top_once", n_top, 1);
    check_val("bounce_zero_once", n_zero, 1);

    // Bar toward LSB, step_div=0
    drive(1'b0, 1'b1, 2'd2, 1'b1, 0);
    tick("bar_restart");
    check_val("bar_start_dark", int'(l), 0);
    for (int i = 0; i < 8; i++) tick("bar_fill");
    check_val("bar_full", int'(l), 'hFF);
    last_l = l;
    tick("bar_wrap");
    check_val("bar_wrap_pulse", int'({l, wrap}), 1);
    dir = 1'b0;
    for (int i = 0; i < 12; i++) tick("bar_up");

    // Freeze mid-count and resume
    drive(1'b0, 1'b1, 2'd0, 1'b0, 4);
    for (int i = 0; i < 7; i++) tick("pre_freeze");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) tick("frozen");
    enable = 1'b1;
    for (int i = 0; i < 10; i++) tick("resume");

    // Reset at pos 6 with enable high
    drive(1'b0, 1'b1, 2'd0, 1'b0, 2);
    n_cyc = 0;
    while (m_pos != 6 && n_cyc < 60) begin
      tick("chase_to6");
      n_cyc++;
    end
    tick("mid_count");
    reset = 1'b1;
    tick("reset_mid");
    check_val("reset_mid_l", int'(l), 'h01);
    check_val("reset_mid_pulses", int'({step, wrap}), 0);
    reset = 1'b0;
    n_cyc = 0;
    while (step !== 1'b1 && n_cyc < 20) begin
      tick("first_step");
      n_cyc++;
    end
    check_val("first_step_latency", n_cyc, 3);

    // Lower step_div below the running count
    step_div = 8'd7;
    for (int i = 0; i < 5; i++) tick("long_count");
    step_div = 8'd1;
    tick("lowered_div");
    check_val("lowered_div_steps", int'(step), 1);

    // Reset appearance in bar and alternate modes
    drive(1'b1, 1'b1, 2'd2, 1'b0, 1);
    tick("reset_bar");
    check_val("reset_l_bar", int'(l), 0);
    mode = 2'd3;
    tick("reset_alt");
    check_val("reset_l_alt", int'(l), 'h55);
    reset = 1'b0;

    // Randomized run
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(0, 99) < 2);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) < 4) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 6) dir = ~dir;
      if ($urandom_range(0, 99) < 6) step_div = DIV_W'($urandom_range(0, 5));
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
